// File: rtl/uint16_digit_emitter_pkg.sv
// Shared types and constants for the uint16 decimal digit emitter.
//   uint16_t / digit_t : data widths of the binary input and one decimal digit
//   state_t            : emitter FSM encoding
//   dabble_step        : one double-dabble iteration over {bcd, binary}
//   msd_index          : position of the most significant nonzero BCD digit
//   bcd_digit          : selects one nibble of the BCD register
package uint16_digit_emitter_pkg;

    localparam int unsigned CONV_STEPS = 16;
    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;

    typedef logic [15:0] uint16_t;
    typedef logic [3:0]  digit_t;
    typedef logic [2:0]  digit_idx_t;
    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_EMIT
    } state_t;

    // Add 3 to every nibble >= 5, then shift {bcd, bin} left by one.
    function automatic logic [BCD_W+15:0] dabble_step(input bcd_t bcd, input uint16_t bin);
        bcd_t adj;
        adj = bcd;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (adj[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], bin, 1'b0};
    endfunction

    // Highest nonzero digit position; falls back to the units digit for zero.
    function automatic digit_idx_t msd_index(input bcd_t bcd);
        digit_idx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) begin
                idx = digit_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic digit_t bcd_digit(input bcd_t bcd, input digit_idx_t idx);
        digit_t d;
        case (idx)
            3'd0:    d = bcd[3:0];
            3'd1:    d = bcd[7:4];
            3'd2:    d = bcd[11:8];
            3'd3:    d = bcd[15:12];
            3'd4:    d = bcd[19:16];
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/UInt16DigitDisplay.sv
// 7-segment decoder for a single decimal digit.
//   digit        : BCD digit 0..9 (values above 9 blank the display)
//   top .. middle: segment enables, active high
//                  (a=top, b=top_right, c=bottom_right, d=bottom,
//                   e=bottom_left, f=top_left, g=middle)
module UInt16DigitDisplay
    import uint16_digit_emitter_pkg::*;
(
    input  digit_t digit,
    output logic   top_left,
    output logic   top,
    output logic   top_right,
    output logic   bottom_right,
    output logic   bottom,
    output logic   bottom_left,
    output logic   middle
);

    logic [6:0] seg_abcdefg;

    always_comb begin
        seg_abcdefg = '0;
        case (digit)
            4'd0: seg_abcdefg = 7'b1111110;
            4'd1: seg_abcdefg = 7'b0110000;
            4'd2: seg_abcdefg = 7'b1101101;
            4'd3: seg_abcdefg = 7'b1111001;
            4'd4: seg_abcdefg = 7'b0110011;
            4'd5: seg_abcdefg = 7'b1011011;
            4'd6: seg_abcdefg = 7'b1011111;
            4'd7: seg_abcdefg = 7'b1110000;
            4'd8: seg_abcdefg = 7'b1111111;
            4'd9: seg_abcdefg = 7'b1111011;
            default: seg_abcdefg = '0;
        endcase
    end

    assign top          = seg_abcdefg[6];
    assign top_right    = seg_abcdefg[5];
    assign bottom_right = seg_abcdefg[4];
    assign bottom       = seg_abcdefg[3];
    assign bottom_left  = seg_abcdefg[2];
    assign top_left     = seg_abcdefg[1];
    assign middle       = seg_abcdefg[0];

endmodule

// File: rtl/uint16_digit_emitter.sv
// Converts a 16-bit unsigned value to decimal with a 16-step double dabble,
// then streams the digits MSD first (no leading zeros) over a valid/ready
// handshake, with a gated 7-segment image of the offered digit.
//   clk, rst      : clock, synchronous active-high reset
//   start, number : conversion request (taken only when idle) and its value
//   busy          : high whenever not idle
//   digit, digit_valid, digit_ready, digit_last : digit stream
//   top_left .. middle : 7-segment image of digit, zero when not valid
module uint16_digit_emitter
    import uint16_digit_emitter_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  uint16_t number,
    output logic    busy,
    output digit_t  digit,
    output logic    digit_valid,
    input  logic    digit_ready,
    output logic    digit_last,
    output logic    top_left,
    output logic    top,
    output logic    top_right,
    output logic    bottom_right,
    output logic    bottom,
    output logic    bottom_left,
    output logic    middle
);

    state_t     state;
    uint16_t    bin_reg;
    bcd_t       bcd_reg;
    logic [4:0] step_cnt;
    digit_idx_t emit_idx;

    logic [BCD_W+15:0] step_res;
    bcd_t              step_bcd;
    uint16_t           step_bin;
    digit_idx_t        step_msd;
    digit_idx_t        next_idx;

    always_comb begin
        step_res = dabble_step(bcd_reg, bin_reg);
        step_bcd = step_res[BCD_W+15:16];
        step_bin = step_res[15:0];
        step_msd = msd_index(step_bcd);
        next_idx = emit_idx - 3'd1;
    end

    // The first digit is loaded on the same edge as the final dabble step,
    // so it is taken from the stepped value rather than from bcd_reg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            bin_reg     <= '0;
            bcd_reg     <= '0;
            step_cnt    <= '0;
            emit_idx    <= '0;
            busy        <= 1'b0;
            digit       <= '0;
            digit_valid <= 1'b0;
            digit_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_reg  <= number;
                        bcd_reg  <= '0;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_reg  <= step_bcd;
                    bin_reg  <= step_bin;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_cnt == 5'(CONV_STEPS - 1)) begin
                        state       <= ST_EMIT;
                        emit_idx    <= step_msd;
                        digit       <= bcd_digit(step_bcd, step_msd);
                        digit_valid <= 1'b1;
                        digit_last  <= (step_msd == 3'd0);
                    end
                end
                ST_EMIT: begin
                    if (digit_ready) begin
                        if (digit_last) begin
                            state       <= ST_IDLE;
                            busy        <= 1'b0;
                            digit       <= '0;
                            digit_valid <= 1'b0;
                            digit_last  <= 1'b0;
                        end else begin
                            emit_idx   <= next_idx;
                            digit      <= bcd_digit(bcd_reg, next_idx);
                            digit_last <= (next_idx == 3'd0);
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    busy        <= 1'b0;
                    digit       <= '0;
                    digit_valid <= 1'b0;
                    digit_last  <= 1'b0;
                end
            endcase
        end
    end

    logic seg_tl, seg_t, seg_tr, seg_br, seg_b, seg_bl, seg_m;

    UInt16DigitDisplay u_display (
        .digit        (digit),
        .top_left     (seg_tl),
        .top          (seg_t),
        .top_right    (seg_tr),
        .bottom_right (seg_br),
        .bottom       (seg_b),
        .bottom_left  (seg_bl),
        .middle       (seg_m)
    );

    assign top_left     = seg_tl & digit_valid;
    assign top          = seg_t  & digit_valid;
    assign top_right    = seg_tr & digit_valid;
    assign bottom_right = seg_br & digit_valid;
    assign bottom       = seg_b  & digit_valid;
    assign bottom_left  = seg_bl & digit_valid;
    assign middle       = seg_m  & digit_valid;

endmodule

// File: tb/tb_uint16_digit_emitter.sv
// Scoreboard bench for uint16_digit_emitter: stimulus pushes expected
// {last, digit} entries, a negedge monitor pops them on every transfer.
module tb_uint16_digit_emitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] number;
    logic        busy;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_ready;
    logic        digit_last;
    logic        top_left, top, top_right, bottom_right, bottom, bottom_left, middle;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [4:0] exp_q[$];

    // Segment images ordered {top_left, top, top_right, bottom_right, bottom, bottom_left, middle}.
    logic [6:0] seg_table [10] = '{
        7'b1111110, 7'b0011000, 7'b0110111, 7'b0111101, 7'b1011001,
        7'b1101101, 7'b1101111, 7'b0111000, 7'b1111111, 7'b1111101
    };

    wire [6:0] segs = {top_left, top, top_right, bottom_right, bottom, bottom_left, middle};

    always #5 clk = ~clk;

    uint16_digit_emitter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .number       (number),
        .busy         (busy),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .digit_last   (digit_last),
        .top_left     (top_left),
        .top          (top),
        .top_right    (top_right),
        .bottom_right (bottom_right),
        .bottom       (bottom),
        .bottom_left  (bottom_left),
        .middle       (middle)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: transfers against the scoreboard, stall stability, idle zeros.
    logic       held = 1'b0;
    logic [3:0] held_digit;
    logic       held_last;
    logic [6:0] held_segs;

    initial begin
        forever begin
            @(negedge clk);
            if (digit_valid) begin
                if (held) begin
                    chk("stall_digit", {28'd0, digit}, {28'd0, held_digit});
                    chk("stall_last", {31'd0, digit_last}, {31'd0, held_last});
                    chk("stall_segs", {25'd0, segs}, {25'd0, held_segs});
                end
                if (digit_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_digit", {28'd0, digit}, 32'hFFFF_FFFF);
                    end else begin
                        logic [4:0] e;
                        e = exp_q.pop_front();
                        chk("digit", {28'd0, digit}, {28'd0, e[3:0]});
                        chk("last", {31'd0, digit_last}, {31'd0, e[4]});
                        chk("segs", {25'd0, segs}, {25'd0, seg_table[e[3:0]]});
                    end
                end else begin
                    held       = 1'b1;
                    held_digit = digit;
                    held_last  = digit_last;
                    held_segs  = segs;
                end
            end else begin
                held = 1'b0;
                if (digit != 4'd0 || segs != 7'd0 || digit_last) begin
                    chk("idle_outputs", {20'd0, digit_last, segs, digit}, 32'd0);
                end
            end
        end
    end

    task automatic push_digits(input int unsigned n, input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] d4);
        logic [3:0] ds [5];
        ds = '{d0, d1, d2, d3, d4};
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), ds[i]});
        end
    endtask

    // Caller is at posedge+1; the edge consumed here is edge N.
    task automatic start_conv(input logic [15:0] n);
        number = n;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int unsigned i;
        for (i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy && !digit_valid) break;
        end
        if (i == 200) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {20'd0, busy, digit_valid, digit_last, segs, digit}, 32'd0);
    endtask

    task automatic chk_queue_empty(input string name);
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; number = '0; digit_ready = 1'b1;
        #1;
        @(posedge clk); #1;
        chk_all_zero("reset_outputs_during");
        start = 1'b1; number = 16'd5;   // rst must win over start
        @(posedge clk); #1;
        chk_all_zero("reset_over_start");
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("after_reset");

        // 12345 with ready held: latency and back-to-back digits
        push_digits(5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        start_conv(16'd12345);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        repeat (15) begin @(posedge clk); #1; end
        chk("valid_before_n16", {31'd0, digit_valid}, 32'd0);
        @(posedge clk); #1;
        chk("valid_at_n17", {31'd0, digit_valid}, 32'd1);
        chk("first_digit_12345", {28'd0, digit}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("no_bubble", {31'd0, digit_valid}, 32'd1);
        end
        @(posedge clk); #1;
        chk("idle_after_last", {30'd0, busy, digit_valid}, 32'd0);
        chk_queue_empty("queue_12345");

        // zero
        push_digits(1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
        start_conv(16'd0);
        wait_idle("zero");
        chk_queue_empty("queue_zero");

        // max value
        push_digits(5, 4'd6, 4'd5, 4'd5, 4'd3, 4'd5);
        start_conv(16'd65535);
        wait_idle("max");
        chk_queue_empty("queue_65535");

        // 100 with ready toggling
        push_digits(3, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        digit_ready = 1'b0;
        start_conv(16'd100);
        begin
            int unsigned i;
            for (i = 0; i < 200; i++) begin
                @(posedge clk); #1;
                if (!busy && !digit_valid) break;
                digit_ready = ~digit_ready;
            end
            if (i == 200) chk("toggle_timeout", 32'd1, 32'd0);
        end
        digit_ready = 1'b1;
        chk_queue_empty("queue_100");

        // restart during CONVERT is ignored
        push_digits(2, 4'd4, 4'd2, 4'd0, 4'd0, 4'd0);
        start_conv(16'd42);
        repeat (3) begin @(posedge clk); #1; end
        start_conv(16'd999);
        wait_idle("ignore_start");
        chk_queue_empty("queue_42");

        // reset while digit 2 of 12345 is offered
        push_digits(1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0);
        exp_q[0] = 5'h01;              // digit 1 transfers but is not last
        start_conv(16'd12345);
        begin
            int unsigned i;
            for (i = 0; i < 40; i++) begin
                if (digit_valid) break;
                @(posedge clk); #1;
            end
            if (i == 40) chk("abort_wait_timeout", 32'd1, 32'd0);
        end
        @(posedge clk); #1;            // digit 1 accepted here
        digit_ready = 1'b0;
        chk("offer_digit2", {28'd0, digit}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        digit_ready = 1'b1;
        chk_all_zero("abort_outputs");
        @(posedge clk); #1;
        chk_all_zero("abort_stays_idle");
        chk_queue_empty("queue_abort");

        push_digits(1, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0);
        start_conv(16'd7);
        wait_idle("seven");
        chk_queue_empty("queue_7");

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uint16_digit_emitter.md
UINT16_DIGIT_EMITTER -- requirements
Module: uint16_digit_emitter

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: request to convert `number`; honoured only in IDLE.
REQ-004 SHALL have port number, input, UInt16: value to emit as decimal digits.
REQ-005 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-006 SHALL have port digit, output, Digit: current decimal digit, 0..9.
REQ-007 SHALL have port digit_valid, output, 1 bit: `digit` is offered.
REQ-008 SHALL have port digit_ready, input, 1 bit: consumer accepts `digit`.
REQ-009 SHALL have port digit_last, output, 1 bit: offered digit is the least significant one.
REQ-010 SHALL have ports top_left, top, top_right, bottom_right, bottom, bottom_left, middle, output, 1 bit each: 7-segment image of `digit`.

Function
REQ-011 SHALL implement three states: IDLE, CONVERT, EMIT.
REQ-012 IDLE: start=1 at edge N SHALL latch `number` into a 16-bit shift register, clear a 20-bit BCD register (5 digits), clear the shift counter, and enter CONVERT.
REQ-013 CONVERT: edges N+1..N+16 SHALL each perform one double-dabble step: add 3 to every BCD nibble >= 5, then shift {BCD, binary} left by 1.
REQ-014 The transition to EMIT SHALL occur at edge N+16, so digit_valid is first high in the cycle after edge N+16.
REQ-015 On entering EMIT, the emit index SHALL be set to the most significant nonzero BCD digit; if all digits are zero, it SHALL be set to the units digit.
REQ-016 EMIT SHALL present digits from most significant to least significant, with no leading zeros; number=0 emits exactly one digit, 0.
REQ-017 While digit_valid=1 and digit_ready=0, digit, digit_last and the segment outputs SHALL remain stable.
REQ-018 A transfer SHALL occur on an edge where digit_valid=1 and digit_ready=1; the next digit SHALL be offered in the following cycle, with no bubble.
REQ-019 digit_last SHALL be high only with the units digit; its transfer SHALL return the block to IDLE, with busy=0 and digit_valid=0 in the next cycle.
REQ-020 start while busy=1 SHALL be ignored, and `number` changes during CONVERT or EMIT SHALL have no effect.
REQ-021 digit_valid SHALL be 0 in IDLE and CONVERT, and digit SHALL read 0 whenever digit_valid=0.
REQ-022 Segment outputs SHALL be the decode of `digit` when digit_valid=1 and all 0 otherwise.
REQ-023 Every BCD nibble SHALL stay <= 9 after each step; 65535 SHALL be the largest value handled (5 digits).

Reset
REQ-024 rst=1 at any edge SHALL force IDLE and clear the binary register, BCD register, counter and index; this aborts CONVERT or EMIT mid-operation with no partial digit delivered afterwards.
REQ-025 During and after reset, outputs SHALL be busy=0, digit=0, digit_valid=0, digit_last=0, and all segments 0.
REQ-026 rst SHALL take precedence over a simultaneous start.

Structure
REQ-027 UInt16, Digit and the FSM state enum SHALL live in the shared types package; the conversion step count (16) and the digit count (5) SHALL be named constants there.
REQ-028 Segment decode SHALL reuse the existing UInt16DigitDisplay sub-module, with its outputs gated by digit_valid; no other sub-module is used.

Verification
REQ-029 With number=12345 and ready held 1, the bench SHALL see digits 1,2,3,4,5 on consecutive cycles, the first at cycle N+17 and last=1 only on 5, then busy=0.
REQ-030 With number=0, the bench SHALL see a single digit 0 with last=1 and segments showing "0".
REQ-031 With number=65535, the bench SHALL see digits 6,5,5,3,5; with number=100 and ready toggling 0/1, it SHALL see 1,0,0, held stable through stalls.
REQ-032 With start pulsed again during CONVERT using number=999 while 42 is in progress, the bench SHALL see only 4,2.
REQ-033 With rst asserted while digit 2 of 12345 is being offered, the bench SHALL see all outputs 0 in the next cycle, and a new start with 7 SHALL emit a single 7.
